// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches, masks and prioritises hw_in sources and
// walks one request at a time through assert, CPU ack and software EOI.
module int_ctrl #(
  parameter int unsigned N_SRC     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h7f30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] hw_in,
  input  logic [31:0]      addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq,
  output logic [2:0]       irq_id,
  input  logic             ack
);

  typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

  state_e           state_q;
  logic [N_SRC-1:0] enable_q, pending_q, mode_q, hw_prev_q;
  logic [N_SRC-1:0] pending_d, rise, clr, req, cur_mask;
  logic [2:0]       cur_id_q, sel;
  logic             irq_q, req_cur;
  logic [31:0]      off;
  logic             in_win, wr_en, wr_enable, wr_pending, wr_mode, wr_claim, eoi_match;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:N_SRC];

  // Offset wraps for addresses below the base, so one compare covers both window ends.
  assign off        = addr - BASE_ADDR;
  assign in_win     = (off[31:4] == 28'd0) && (off[1:0] == 2'b00);
  assign wr_en      = we && in_win;
  assign wr_enable  = wr_en && (off[3:2] == 2'd0);
  assign wr_pending = wr_en && (off[3:2] == 2'd1);
  assign wr_mode    = wr_en && (off[3:2] == 2'd2);
  assign wr_claim   = wr_en && (off[3:2] == 2'd3);
  assign eoi_match  = wr_claim && (wdata[2:0] == cur_id_q);

  assign req     = pending_q & enable_q;
  assign rise    = hw_in & ~hw_prev_q;
  assign req_cur = |(req & cur_mask);

  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel = 3'(i);
    end
  end

  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cur_mask[i] = (cur_id_q == 3'(i));
    end
  end

  // Edge bits: a new rising edge beats any clear in the same cycle. Level bits follow hw_in.
  always_comb begin
    clr = '0;
    if (wr_pending) clr = wdata[N_SRC-1:0];
    if ((state_q == StAssert) && ack) clr = clr | cur_mask;
    pending_d = (mode_q & ((pending_q & ~clr) | rise)) | (~mode_q & hw_in);
  end

  always_comb begin
    rdata = '0;
    if (in_win) begin
      unique case (off[3:2])
        2'd0: rdata = 32'(enable_q);
        2'd1: rdata = 32'(pending_q);
        2'd2: rdata = 32'(mode_q);
        2'd3: rdata = {state_q == StService, 28'd0, cur_id_q};
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      enable_q  <= '0;
      pending_q <= '0;
      mode_q    <= '0;
      hw_prev_q <= '0;
      cur_id_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      hw_prev_q <= hw_in;
      pending_q <= pending_d;
      if (wr_enable) enable_q <= wdata[N_SRC-1:0];
      if (wr_mode)   mode_q   <= wdata[N_SRC-1:0];
      case (state_q)
        StIdle: begin
          if (|req) begin
            cur_id_q <= sel;
            irq_q    <= 1'b1;
            state_q  <= StAssert;
          end
        end
        StAssert: begin
          if (ack) begin
            irq_q   <= 1'b0;
            state_q <= StService;
          end else if (!req_cur) begin
            // Request withdrawn before the CPU took it: drop without needing an ack.
            irq_q    <= 1'b0;
            cur_id_q <= '0;
            state_q  <= StIdle;
          end
        end
        StService: begin
          if (eoi_match) begin
            cur_id_q <= '0;
            state_q  <= StIdle;
          end
        end
        default: begin
          irq_q    <= 1'b0;
          cur_id_q <= '0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign irq    = irq_q;
  assign irq_id = cur_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the controller.
module tb_int_ctrl;

  localparam logic [31:0] BASE = 32'h7f30;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  hw_in = '0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;
  logic [2:0]  irq_id;
  logic        ack = 1'b0;

  int checks = 0;
  int errors = 0;

  int_ctrl #(.N_SRC(6), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .hw_in  (hw_in),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq),
    .irq_id (irq_id),
    .ack    (ack)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = idle, 1 = request raised to CPU, 2 = CPU servicing m_cur
  logic [5:0] m_en = '0, m_mode = '0, m_pend = '0, m_prev = '0;
  int         m_phase = 0;
  int         m_cur = 0;

  function automatic int reg_index(input logic [31:0] a);
    if (a >= BASE && a <= BASE + 32'd15 && (a % 4) == 0) return int'((a - BASE) / 4);
    return -1;
  endfunction

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (reg_index(a))
      0: return {26'd0, m_en};
      1: return {26'd0, m_pend};
      2: return {26'd0, m_mode};
      3: return {(m_phase == 2), 28'd0, 3'(m_cur)};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [5:0] req_v, nxt_v;
    int         tgt;
    if (!reset) begin
      m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0; m_phase = 0; m_cur = 0;
    end else begin
      tgt   = we ? reg_index(addr) : -1;
      req_v = m_pend & m_en;
      for (int i = 0; i < 6; i++) begin
        if (!m_mode[i]) nxt_v[i] = hw_in[i];
        else if (hw_in[i] && !m_prev[i]) nxt_v[i] = 1'b1;
        else if ((tgt == 1 && wdata[i]) || (m_phase == 1 && ack && m_cur == i)) nxt_v[i] = 1'b0;
        else nxt_v[i] = m_pend[i];
      end
      case (m_phase)
        0: if (req_v != 0) begin m_phase = 1; m_cur = lowest(req_v); end
        1: begin
          if (ack) m_phase = 2;
          else if (!req_v[m_cur]) begin m_phase = 0; m_cur = 0; end
        end
        default: if (tgt == 3 && int'(wdata[2:0]) == m_cur) begin m_phase = 0; m_cur = 0; end
      endcase
      m_pend = nxt_v;
      if (tgt == 0) m_en = wdata[5:0];
      if (tgt == 2) m_mode = wdata[5:0];
      m_prev = hw_in;
    end
  end

  // ---------------- cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    exp_rd = model_read(addr);
    checks++;
    if (irq !== (m_phase == 1)) begin
      errors++;
      $display("FAIL cyc_irq t=%0t: got %b expected %b", $time, irq, (m_phase == 1));
    end
    if (m_phase == 1) begin
      checks++;
      if (irq_id !== 3'(m_cur)) begin
        errors++;
        $display("FAIL cyc_irq_id t=%0t: got %0d expected %0d", $time, irq_id, m_cur);
      end
    end
    checks++;
    if (rdata !== exp_rd) begin
      errors++;
      $display("FAIL cyc_rdata t=%0t addr=%h: got %h expected %h", $time, addr, rdata, exp_rd);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  logic [31:0] alist [9];

  initial begin
    int idx;
    alist[0] = BASE;          alist[1] = BASE + 32'h4;  alist[2] = BASE + 32'h8;
    alist[3] = BASE + 32'hc;  alist[4] = BASE + 32'h1;  alist[5] = BASE + 32'h6;
    alist[6] = BASE + 32'h10; alist[7] = BASE - 32'h4;  alist[8] = 32'h0;

    // 1: reset held with all lines high
    hw_in = 6'h3f;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      read_check("t1_reg", BASE + 32'(4 * i), 32'h0);
      check("t1_irq", {31'd0, irq}, 32'd0);
    end
    reset = 1'b1;
    hw_in = 6'h00;
    tick(); tick();
    check("t1_irq_after", {31'd0, irq}, 32'd0);

    // 2: edge source 0, single pulse, ack, EOI
    write(BASE + 32'h0, 32'h01);
    write(BASE + 32'h8, 32'h01);
    hw_in = 6'h01;
    tick();
    hw_in = 6'h00;
    read_check("t2_pend_set", BASE + 32'h4, 32'h1);
    check("t2_irq_low", {31'd0, irq}, 32'd0);
    tick();
    check("t2_irq_high", {31'd0, irq}, 32'd1);
    check("t2_irq_id", {29'd0, irq_id}, 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t2_irq_ack", {31'd0, irq}, 32'd0);
    read_check("t2_pend_clr", BASE + 32'h4, 32'h0);
    read_check("t2_claim_svc", BASE + 32'hc, 32'h8000_0000);
    write(BASE + 32'hc, 32'h0);
    read_check("t2_claim_eoi", BASE + 32'hc, 32'h0);

    // 3 + 4: level sources 1 and 2 together, wrong-ID EOI, then right EOI
    write(BASE + 32'h8, 32'h00);
    write(BASE + 32'h0, 32'h07);
    hw_in = 6'h06;
    tick(); tick();
    check("t3_irq", {31'd0, irq}, 32'd1);
    check("t3_irq_id", {29'd0, irq_id}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    write(BASE + 32'hc, 32'h2);
    read_check("t4_claim_keep", BASE + 32'hc, 32'h8000_0001);
    check("t4_irq_low", {31'd0, irq}, 32'd0);
    hw_in = 6'h04;
    write(BASE + 32'hc, 32'h1);
    read_check("t4_claim_eoi", BASE + 32'hc, 32'h0);
    check("t3_irq_gap", {31'd0, irq}, 32'd0);
    tick();
    check("t3_irq_again", {31'd0, irq}, 32'd1);
    check("t3_irq_id2", {29'd0, irq_id}, 32'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    hw_in = 6'h00;
    write(BASE + 32'hc, 32'h2);
    tick();

    // 5: disable while asserting, then re-enable
    write(BASE + 32'h8, 32'h01);
    write(BASE + 32'h0, 32'h01);
    hw_in = 6'h01;
    tick();
    hw_in = 6'h00;
    tick();
    check("t5_irq", {31'd0, irq}, 32'd1);
    write(BASE + 32'h0, 32'h00);
    tick();
    check("t5_irq_drop", {31'd0, irq}, 32'd0);
    read_check("t5_pend_kept", BASE + 32'h4, 32'h1);
    read_check("t5_claim_idle", BASE + 32'hc, 32'h0);
    write(BASE + 32'h0, 32'h01);
    tick();
    check("t5_irq_back", {31'd0, irq}, 32'd1);
    check("t5_irq_id", {29'd0, irq_id}, 32'd0);

    // 6: W1C racing a new edge, then reset in service
    ack = 1'b1;
    tick();
    ack = 1'b0;
    hw_in = 6'h01;
    write(BASE + 32'h4, 32'h01);
    read_check("t6_pend_setwins", BASE + 32'h4, 32'h1);
    read_check("t6_claim_svc", BASE + 32'hc, 32'h8000_0000);
    reset = 1'b0;
    #1;
    check("t6_rst_irq", {31'd0, irq}, 32'd0);
    check("t6_rst_id", {29'd0, irq_id}, 32'd0);
    check("t6_rst_claim", rdata, 32'h0);
    tick();
    hw_in = 6'h00;
    reset = 1'b1;
    tick();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) hw_in = hw_in ^ (6'd1 << $urandom_range(0, 5));
      ack = ($urandom_range(0, 3) == 0);
      we  = ($urandom_range(0, 2) == 0);
      idx = $urandom_range(0, 12);
      addr  = alist[(idx < 8) ? (idx % 4) : (idx - 4)];
      wdata = $urandom;
      if (addr == BASE + 32'hc && $urandom_range(0, 1) == 1) wdata[2:0] = 3'(m_cur);
      tick();
    end
    we = 1'b0;
    ack = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
